// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave backed by a small word-addressed register memory.
// One outstanding transaction per direction; reads and writes proceed independently.
module axi_lite_slave_mem #(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] AWADDR,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  input  logic        WVALID,
  output logic        WREADY,
  output logic [1:0]  BRESP,
  output logic        BVALID,
  input  logic        BREADY,
  input  logic [31:0] ARADDR,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RVALID,
  input  logic        RREADY
);

  localparam int          AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] SPAN        = 33'(DEPTH) << 2;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic in_range(input logic [31:0] addr);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, BASE_ADDR};
    return (addr >= BASE_ADDR) && (off < SPAN);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
    return AW'((addr - BASE_ADDR) >> 2);
  endfunction

  w_state_t    w_state_reg, w_state_next;
  logic        aw_latched_reg, aw_latched_next;
  logic [31:0] awaddr_reg, awaddr_next;
  logic        w_latched_reg, w_latched_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [3:0]  wstrb_reg, wstrb_next;
  logic [1:0]  bresp_reg, bresp_next;

  r_state_t    r_state_reg, r_state_next;
  logic [31:0] rdata_reg, rdata_next;
  logic [1:0]  rresp_reg, rresp_next;

  logic [31:0] mem [DEPTH];
  logic        mem_we;

  logic        aw_fire, w_fire, ar_fire;
  logic [31:0] wr_addr, wr_data, wr_mask;
  logic [3:0]  wr_strb;
  logic        wr_ok, rd_ok;
  logic [AW-1:0] wr_idx, rd_idx;

  // Ready outputs are gated by rst so they read 0 throughout reset.
  assign AWREADY = rst && (w_state_reg == W_IDLE) && !aw_latched_reg;
  assign WREADY  = rst && (w_state_reg == W_IDLE) && !w_latched_reg;
  assign BVALID  = (w_state_reg == W_RESP);
  assign BRESP   = bresp_reg;
  assign ARREADY = rst && (r_state_reg == R_IDLE);
  assign RVALID  = (r_state_reg == R_DATA);
  assign RDATA   = rdata_reg;
  assign RRESP   = rresp_reg;

  assign aw_fire = AWVALID && AWREADY;
  assign w_fire  = WVALID && WREADY;
  assign ar_fire = ARVALID && ARREADY;

  // A channel accepted on this very edge is used directly, bypassing its latch.
  assign wr_addr = aw_latched_reg ? awaddr_reg : AWADDR;
  assign wr_data = w_latched_reg ? wdata_reg : WDATA;
  assign wr_strb = w_latched_reg ? wstrb_reg : WSTRB;
  assign wr_ok   = in_range(wr_addr);
  assign wr_idx  = word_idx(wr_addr);
  assign rd_ok   = in_range(ARADDR);
  assign rd_idx  = word_idx(ARADDR);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wr_mask[gi*8 +: 8] = {8{wr_strb[gi]}};
    end
  endgenerate

  always_comb begin
    w_state_next    = w_state_reg;
    aw_latched_next = aw_latched_reg;
    awaddr_next     = awaddr_reg;
    w_latched_next  = w_latched_reg;
    wdata_next      = wdata_reg;
    wstrb_next      = wstrb_reg;
    bresp_next      = bresp_reg;
    mem_we          = 1'b0;
    case (w_state_reg)
      W_IDLE: begin
        if (aw_fire) begin
          aw_latched_next = 1'b1;
          awaddr_next     = AWADDR;
        end
        if (w_fire) begin
          w_latched_next = 1'b1;
          wdata_next     = WDATA;
          wstrb_next     = WSTRB;
        end
        if ((aw_latched_reg || aw_fire) && (w_latched_reg || w_fire)) begin
          w_state_next    = W_RESP;
          aw_latched_next = 1'b0;
          w_latched_next  = 1'b0;
          bresp_next      = wr_ok ? RESP_OKAY : RESP_SLVERR;
          mem_we          = wr_ok;
        end
      end
      W_RESP: begin
        if (BREADY) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_next = r_state_reg;
    rdata_next   = rdata_reg;
    rresp_next   = rresp_reg;
    case (r_state_reg)
      R_IDLE: begin
        if (ar_fire) begin
          r_state_next = R_DATA;
          rdata_next   = rd_ok ? mem[rd_idx] : 32'h0;
          rresp_next   = rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_DATA: begin
        if (RREADY) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_state_reg    <= W_IDLE;
      aw_latched_reg <= 1'b0;
      awaddr_reg     <= '0;
      w_latched_reg  <= 1'b0;
      wdata_reg      <= '0;
      wstrb_reg      <= '0;
      bresp_reg      <= RESP_OKAY;
      r_state_reg    <= R_IDLE;
      rdata_reg      <= '0;
      rresp_reg      <= RESP_OKAY;
    end else begin
      w_state_reg    <= w_state_next;
      aw_latched_reg <= aw_latched_next;
      awaddr_reg     <= awaddr_next;
      w_latched_reg  <= w_latched_next;
      wdata_reg      <= wdata_next;
      wstrb_reg      <= wstrb_next;
      bresp_reg      <= bresp_next;
      r_state_reg    <= r_state_next;
      rdata_reg      <= rdata_next;
      rresp_reg      <= rresp_next;
    end
  end

  // Reads sample mem before this edge's write lands, so a colliding read sees old data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[wr_idx] <= (mem[wr_idx] & ~wr_mask) | (wr_data & wr_mask);
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Randomized bench for axi_lite_slave_mem: a cycle-level behavioural model is compared
// against the DUT every cycle, plus literal checks for the directed scenarios.
module tb_axi_lite_slave_mem;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] AWADDR = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [31:0] ARADDR = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY = 1'b0;

  always #5 clk = ~clk;

  axi_lite_slave_mem #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [DEPTH];
  bit          m_have_aw, m_have_w, m_bpend, m_rpend;
  logic [31:0] m_aw_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;

  function automatic bit m_in_range(input logic [31:0] a);
    longint unsigned la;
    la = longint'(a);
    return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * DEPTH);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  always @(posedge clk) begin
    bit awr, wr;
    awr = !m_bpend && !m_have_aw;
    wr  = !m_bpend && !m_have_w;
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_have_aw = 0; m_have_w = 0; m_bpend = 0; m_rpend = 0;
      m_bresp = 2'b00; m_rdata = '0; m_rresp = 2'b00;
    end else begin
      // read first: a colliding write on this edge must not be visible
      if (m_rpend) begin
        if (RREADY) m_rpend = 0;
      end else if (ARVALID) begin
        m_rpend = 1;
        if (m_in_range(ARADDR)) begin
          m_rdata = m_mem[m_idx(ARADDR)];
          m_rresp = 2'b00;
        end else begin
          m_rdata = '0;
          m_rresp = 2'b10;
        end
      end
      if (m_bpend) begin
        if (BREADY) m_bpend = 0;
      end else begin
        if (AWVALID && awr) begin m_have_aw = 1; m_aw_addr = AWADDR; end
        if (WVALID && wr) begin m_have_w = 1; m_wdata = WDATA; m_wstrb = WSTRB; end
        if (m_have_aw && m_have_w) begin
          if (m_in_range(m_aw_addr)) begin
            for (int b = 0; b < 4; b++)
              if (m_wstrb[b]) m_mem[m_idx(m_aw_addr)][8*b +: 8] = m_wdata[8*b +: 8];
            m_bresp = 2'b00;
          end else begin
            m_bresp = 2'b10;
          end
          m_bpend = 1; m_have_aw = 0; m_have_w = 0;
        end
      end
    end
    #1;
    check("awready", AWREADY, rst && !m_bpend && !m_have_aw);
    check("wready",  WREADY,  rst && !m_bpend && !m_have_w);
    check("arready", ARREADY, rst && !m_rpend);
    check("bvalid",  BVALID,  m_bpend);
    check("rvalid",  RVALID,  m_rpend);
    if (!rst || m_bpend) check("bresp", BRESP, m_bresp);
    if (!rst || m_rpend) begin
      check("rdata", RDATA, m_rdata);
      check("rresp", RRESP, m_rresp);
    end
  end

  // ---------------- transaction drivers ----------------
  task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_hold,
                           output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int cyc = 0;
    int n = 0;
    resp = 2'bxx;
    while (!(aw_done && w_done)) begin
      @(negedge clk);
      AWADDR  = a; WDATA = d; WSTRB = s;
      AWVALID = !aw_done && (cyc >= aw_dly);
      WVALID  = !w_done && (cyc >= w_dly);
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      @(posedge clk);
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      cyc++;
      if (cyc > 100) begin
        timeout_fail("write_addr_data");
        break;
      end
    end
    @(negedge clk);
    AWVALID = 1'b0; WVALID = 1'b0;
    // while the response is held off, offer a stray AW/W that must be ignored
    for (int i = 0; i < b_hold; i++) begin
      AWVALID = (i == 0); AWADDR = 32'h0000_0000;
      WVALID  = (i == 0); WDATA  = 32'hFFFF_FFFF; WSTRB = 4'hF;
      @(negedge clk);
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    BREADY = 1'b1;
    while (!BVALID && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeout_fail("write_resp");
    resp = BRESP;
    @(posedge clk);
    @(negedge clk);
    BREADY = 1'b0;
    $display("write addr=%h data=%h strb=%h resp=%0d", a, d, s, resp);
  endtask

  task automatic read_txn(input logic [31:0] a, input int ar_dly, input int r_hold,
                          output logic [31:0] data, output logic [1:0] resp);
    bit done = 0, hs;
    int cyc = 0;
    int n = 0;
    data = 'x; resp = 2'bxx;
    while (!done) begin
      @(negedge clk);
      ARADDR  = a;
      ARVALID = (cyc >= ar_dly);
      hs = ARVALID && ARREADY;
      @(posedge clk);
      if (hs) done = 1;
      cyc++;
      if (cyc > 100) begin
        timeout_fail("read_addr");
        break;
      end
    end
    @(negedge clk);
    ARVALID = 1'b0;
    repeat (r_hold) @(negedge clk);
    RREADY = 1'b1;
    while (!RVALID && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeout_fail("read_data");
    data = RDATA;
    resp = RRESP;
    @(posedge clk);
    @(negedge clk);
    RREADY = 1'b0;
    $display("read  addr=%h data=%h resp=%0d", a, data, resp);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  r1, r2;
    logic [31:0] d1;

    repeat (3) @(negedge clk);
    check("rst_bvalid", BVALID, 1'b0);
    check("rst_rvalid", RVALID, 1'b0);
    check("rst_rdata",  RDATA,  32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_awready", AWREADY, 1'b1);
    check("post_rst_wready",  WREADY,  1'b1);
    check("post_rst_arready", ARREADY, 1'b1);

    // simultaneous AW/W, full strobe
    write_txn(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, r1);
    check("wr04_bresp", r1, 2'b00);
    read_txn(32'h04, 0, 0, d1, r2);
    check("rd04_data", d1, 32'hDEADBEEF);
    check("rd04_resp", r2, 2'b00);

    // W three cycles ahead of AW, partial strobe
    write_txn(32'h08, 32'h11223344, 4'b0101, 3, 0, 0, r1);
    check("wr08_bresp", r1, 2'b00);
    read_txn(32'h08, 0, 0, d1, r2);
    check("rd08_data", d1, 32'h00220044);

    // first address past the end
    write_txn(32'h40, 32'h12345678, 4'hF, 0, 0, 0, r1);
    check("wr40_bresp", r1, 2'b10);
    read_txn(32'h40, 0, 0, d1, r2);
    check("rd40_data", d1, 32'h0);
    check("rd40_resp", r2, 2'b10);
    read_txn(32'h00, 0, 0, d1, r2);
    check("rd00_untouched", d1, 32'h0);

    // both responses held off for 5 cycles
    fork
      write_txn(32'h10, 32'hCAFEF00D, 4'hF, 1, 0, 5, r1);
      read_txn(32'h04, 0, 5, d1, r2);
    join
    check("hold_bresp", r1, 2'b00);
    check("hold_rdata", d1, 32'hDEADBEEF);

    // zero strobe leaves the word alone
    write_txn(32'h10, 32'h0000_0000, 4'h0, 0, 0, 0, r1);
    check("wstrb0_bresp", r1, 2'b00);
    read_txn(32'h10, 0, 0, d1, r2);
    check("wstrb0_data", d1, 32'hCAFEF00D);

    // write commit and AR on the same edge
    write_txn(32'h0C, 32'hA5A5A5A5, 4'hF, 0, 0, 0, r1);
    fork
      write_txn(32'h0C, 32'h5A5A5A5A, 4'hF, 0, 0, 0, r1);
      read_txn(32'h0C, 0, 0, d1, r2);
    join
    check("collide_old", d1, 32'hA5A5A5A5);
    read_txn(32'h0C, 0, 0, d1, r2);
    check("collide_new", d1, 32'h5A5A5A5A);

    // randomized traffic, checked by the model
    for (int t = 0; t < 40; t++) begin
      int kind;
      logic [31:0] wa, ra, wd;
      logic [3:0]  ws;
      int a_d, w_d, b_h, r_d, r_h;
      logic [31:0] rd;
      logic [1:0]  wr_r, rd_r;
      kind = $urandom_range(0, 2);
      wa  = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      ra  = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      wd  = $urandom;
      ws  = 4'($urandom_range(0, 15));
      a_d = $urandom_range(0, 3); w_d = $urandom_range(0, 3); b_h = $urandom_range(0, 3);
      r_d = $urandom_range(0, 3); r_h = $urandom_range(0, 3);
      case (kind)
        0: write_txn(wa, wd, ws, a_d, w_d, b_h, wr_r);
        1: read_txn(ra, r_d, r_h, rd, rd_r);
        default: fork
          write_txn(wa, wd, ws, a_d, w_d, b_h, wr_r);
          read_txn(ra, r_d, r_h, rd, rd_r);
        join
      endcase
    end

    // reset while a write response is pending
    @(negedge clk);
    AWADDR = 32'h04; AWVALID = 1'b1;
    WDATA = 32'h13579BDF; WSTRB = 4'hF; WVALID = 1'b1;
    BREADY = 1'b0;
    @(negedge clk);
    AWVALID = 1'b0; WVALID = 1'b0;
    check("pre_rst_bvalid", BVALID, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_bvalid", BVALID, 1'b0);
    rst = 1'b1;
    BREADY = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("after_rst_no_b", BVALID, 1'b0);
    end
    BREADY = 1'b0;
    read_txn(32'h04, 0, 0, d1, r2);
    check("after_rst_rd04", d1, 32'h0);
    read_txn(32'h0C, 0, 0, d1, r2);
    check("after_rst_rd0c", d1, 32'h0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_slave_mem.md
AXI_LITE_SLAVE_MEM -- requirements
Module: axi_lite_slave_mem

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter DEPTH SHALL default to 16 and set the number of 32-bit memory words.
REQ-003 Parameter BASE_ADDR SHALL default to 32'h0000_0000 and set the byte address of word 0.
REQ-004 Port clk SHALL be an input, 1 bit: the system clock; all logic updates on its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit: synchronous reset, active low.
REQ-006 Ports AWADDR (input, 32) and AWVALID (input, 1) and AWREADY (output, 1) SHALL form the write-address channel.
REQ-007 Ports WDATA (input, 32), WSTRB (input, 4), WVALID (input, 1) and WREADY (output, 1) SHALL form the write-data channel.
REQ-008 Ports BRESP (output, 2), BVALID (output, 1) and BREADY (input, 1) SHALL form the write-response channel.
REQ-009 Ports ARADDR (input, 32), ARVALID (input, 1) and ARREADY (output, 1) SHALL form the read-address channel.
REQ-010 Ports RDATA (output, 32), RRESP (output, 2), RVALID (output, 1) and RREADY (input, 1) SHALL form the read-data channel.

Function
REQ-011 A handshake SHALL occur on a rising edge where VALID and READY are both 1; no other event transfers data.
REQ-012 The word index SHALL be (addr - BASE_ADDR) >> 2; addr[1:0] SHALL be ignored.
REQ-013 An address SHALL be in range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH; in range gives RESP 2'b00 (OKAY), out of range gives 2'b10 (SLVERR).
REQ-014 The write FSM SHALL have states W_IDLE (collecting AW and W) and W_RESP (BVALID high).
REQ-015 In W_IDLE, AWREADY SHALL be 1 while no address is latched, and WREADY SHALL be 1 while no data is latched; AW and W SHALL be accepted in either order or on the same edge.
REQ-016 On the edge where both address and data become latched, the FSM SHALL go to W_RESP; in the next cycle BVALID=1 and BRESP is valid, giving one cycle of latency after the later handshake.
REQ-017 The memory SHALL be updated on that same edge, one byte lane per set WSTRB bit; WSTRB=4'b0000 SHALL leave memory unchanged with BRESP OKAY; an out-of-range write SHALL not modify memory.
REQ-018 In W_RESP, AWREADY and WREADY SHALL be 0; BVALID and BRESP SHALL hold until the B handshake, after which the FSM returns to W_IDLE with both latches empty.
REQ-019 The read FSM SHALL have states R_IDLE (ARREADY=1) and R_DATA (ARREADY=0, RVALID=1).
REQ-020 On an AR handshake, RDATA SHALL be loaded from memory (or 32'h0 if out of range) together with RRESP, and RVALID SHALL be 1 in the next cycle.
REQ-021 RDATA, RRESP and RVALID SHALL hold stable until the R handshake, after which the FSM returns to R_IDLE and ARREADY=1 in the following cycle.
REQ-022 The read and write paths SHALL be independent; a write commit and an AR handshake on the same edge to the same word SHALL return the pre-write data.
REQ-023 VALID inputs that drop without a handshake SHALL have no effect; no outstanding depth beyond one transaction per direction SHALL be supported.

Reset
REQ-024 While rst=0 at a rising edge: both FSMs SHALL go to idle, latches clear, all memory words set to 32'h0, and AWREADY, WREADY, ARREADY, BVALID and RVALID SHALL be 0. RDATA, BRESP and RRESP SHALL be 0.
REQ-025 In the first cycle after rst returns to 1, AWREADY, WREADY and ARREADY SHALL be 1.
REQ-026 A reset mid-transaction SHALL discard any latched address, data or pending response without generating BVALID or RVALID.

Verification
REQ-027 Write to 0x04 with WDATA 0xDEADBEEF and WSTRB 4'hF, AW and W on the same edge, BREADY=1 -> BVALID one cycle later, BRESP 2'b00; reading 0x04 then returns 0xDEADBEEF with RRESP 2'b00.
REQ-028 W handshake 3 cycles before AW (addr 0x08, data 0x11223344, WSTRB 4'b0101), then read 0x08 -> RDATA 0x00220044.
REQ-029 Write to 0x40 (DEPTH=16) -> BRESP 2'b10 and memory unchanged; read 0x40 -> RDATA 0, RRESP 2'b10.
REQ-030 BREADY and RREADY held low for 5 cycles -> BVALID, RVALID, RDATA and BRESP stay stable, with AWREADY=WREADY=ARREADY=0 throughout.
REQ-031 Word 0x0C holds 0xA5A5A5A5; write 0x5A5A5A5A commits on the same edge as an AR handshake to 0x0C -> RDATA 0xA5A5A5A5; a following read returns 0x5A5A5A5A.
REQ-032 rst=0 asserted while BVALID=1 -> BVALID=0 on the next edge, no B response after release, and a read of any previously written word returns 0.
